// File: rtl/alu16_nibble_sequencer.sv
// rtl/alu16_nibble_sequencer.sv - 16-bit ALU operations sequenced one nibble per cycle through an external 4-bit ALU
module alu16_nibble_sequencer #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES,
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic [3:0]   op_sel,
   input  logic         op_mode,
   input  logic         op_cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         is_equal,
   output logic [3:0]   alu_a,
   output logic [3:0]   alu_b,
   output logic [3:0]   alu_select,
   output logic         alu_mode,
   output logic         alu_cin,
   input  logic [3:0]   alu_f,
   input  logic         alu_cout,
   input  logic         alu_eq
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  a_lat, b_lat;
   logic [3:0]    sel_lat;
   logic          mode_lat, cin_lat;
   logic [IW-1:0] idx;
   logic          carry, eq_acc;
   logic          last;

   assign last = (idx == IW'(NIBBLES - 1));
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_lat    <= '0;
         b_lat    <= '0;
         sel_lat  <= '0;
         mode_lat <= 1'b0;
         cin_lat  <= 1'b0;
         idx      <= '0;
         carry    <= 1'b1;
         eq_acc   <= 1'b0;
         result   <= '0;
         cout     <= 1'b1;
         is_equal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_lat    <= op_a;
                  b_lat    <= op_b;
                  sel_lat  <= op_sel;
                  mode_lat <= op_mode;
                  cin_lat  <= op_cin;
                  idx      <= '0;
                  eq_acc   <= 1'b1;
               end
            end
            RUN: begin
               result[{idx, 2'b00} +: 4] <= alu_f;
               carry  <= alu_cout;
               eq_acc <= eq_acc & alu_eq;
               idx    <= last ? '0 : idx + 1'b1;
               if (last) begin
                  // Logic-mode carry-out is meaningless, so report "no carry".
                  cout     <= mode_lat ? 1'b1 : alu_cout;
                  is_equal <= eq_acc & alu_eq;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      alu_a      = 4'h0;
      alu_b      = 4'h0;
      alu_select = 4'h0;
      alu_mode   = 1'b0;
      alu_cin    = 1'b1;
      if (state == RUN) begin
         alu_a      = a_lat[{idx, 2'b00} +: 4];
         alu_b      = b_lat[{idx, 2'b00} +: 4];
         alu_select = sel_lat;
         alu_mode   = mode_lat;
         alu_cin    = mode_lat ? 1'b1 : ((idx == '0) ? cin_lat : carry);
      end
   end

endmodule

// File: tb/tb_alu16_nibble_sequencer.sv
// tb/tb_alu16_nibble_sequencer.sv - scoreboard bench for alu16_nibble_sequencer with a 4-bit ALU stand-in
module tb_alu16_nibble_sequencer;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] op_a, op_b;
   logic [3:0]  op_sel;
   logic        op_mode, op_cin;
   logic        busy, done, cout, is_equal;
   logic [15:0] result;
   logic [3:0]  alu_a, alu_b, alu_select, alu_f;
   logic        alu_mode, alu_cin, alu_cout, alu_eq;

   int vectors = 0;
   int miscompares = 0;
   int dones = 0;
   int issued = 0;

   typedef struct {
      logic [15:0] r;
      logic        c;
      logic        e;
      logic        m;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu16_nibble_sequencer #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .op_sel(op_sel), .op_mode(op_mode), .op_cin(op_cin),
      .busy(busy), .done(done), .result(result), .cout(cout), .is_equal(is_equal),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
      .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout), .alu_eq(alu_eq)
   );

   // Bitwise 74181-style logic functions, valid at any width since they are bit-local.
   function automatic logic [15:0] logic_fn(input logic [15:0] a, b, input logic [3:0] s);
      case (s)
         4'd0:  return ~a;
         4'd1:  return ~(a | b);
         4'd2:  return ~a & b;
         4'd3:  return 16'h0000;
         4'd4:  return ~(a & b);
         4'd5:  return ~b;
         4'd6:  return a ^ b;
         4'd7:  return a & ~b;
         4'd8:  return ~a | b;
         4'd9:  return ~(a ^ b);
         4'd10: return b;
         4'd11: return a & b;
         4'd12: return 16'hFFFF;
         4'd13: return a | ~b;
         4'd14: return a | b;
         default: return a;
      endcase
   endfunction

   // Second addend of the supported arithmetic functions: A+B, A-B-1, A+A, A-1.
   function automatic logic [15:0] addend(input logic [15:0] a, b, input logic [3:0] s);
      case (s)
         4'd9:  return b;
         4'd6:  return ~b;
         4'd12: return a;
         default: return 16'hFFFF;
      endcase
   endfunction

   // 4-bit ALU stand-in.
   always_comb begin
      logic [15:0] lf, ad;
      logic [4:0]  s5;
      lf = logic_fn({12'h0, alu_a}, {12'h0, alu_b}, alu_select);
      ad = addend({12'h0, alu_a}, {12'h0, alu_b}, alu_select);
      s5 = {1'b0, alu_a} + {1'b0, ad[3:0]} + {4'b0, ~alu_cin};
      alu_eq = (alu_a == alu_b);
      if (alu_mode) begin
         alu_f    = lf[3:0];
         alu_cout = 1'b1;
      end else begin
         alu_f    = s5[3:0];
         alu_cout = ~s5[4];
      end
   end

   // Whole-word reference.
   function automatic exp_t ref_model(input logic [15:0] a, b, input logic [3:0] s,
                                      input logic m, ci);
      exp_t e;
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, addend(a, b, s)} + {16'h0, ~ci};
      e.m = m;
      e.e = (a == b);
      if (m) begin
         e.r = logic_fn(a, b, s);
         e.c = 1'b1;
      end else begin
         e.r = sum[15:0];
         e.c = ~sum[16];
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops and compares whenever done is presented.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && !done && sb.size() > 0 && sb[0].m)
            check("alu_cin_logic", {31'h0, alu_cin}, 32'h1);
         if (done) begin
            dones++;
            if (sb.size() == 0) begin
               check("spurious_done", 32'h1, 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", {16'h0, result}, {16'h0, e.r});
               check("cout", {31'h0, cout}, {31'h0, e.c});
               check("is_equal", {31'h0, is_equal}, {31'h0, e.e});
            end
         end
      end
   end

   // dup_at: negedge index at which a second (ignored) start pulse is raised; 0 = none.
   // rst_at: negedge index at which reset is asserted mid-operation; 0 = none.
   task automatic run_op(input logic [15:0] a, b, input logic [3:0] s, input logic m, ci,
                         input int dup_at, input int rst_at);
      exp_t e;
      e = ref_model(a, b, s, m, ci);
      @(negedge clk);
      op_a = a; op_b = b; op_sel = s; op_mode = m; op_cin = ci; start = 1'b1;
      if (rst_at == 0) begin
         sb.push_back(e);
         issued++;
      end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == dup_at) begin
            op_a = ~a; op_b = a; op_sel = 4'd12; start = 1'b1;
         end
         if (k == rst_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_busy", {31'h0, busy}, 32'h0);
            check("rst_done", {31'h0, done}, 32'h0);
            check("rst_result", {16'h0, result}, 32'h0);
            check("rst_cout", {31'h0, cout}, 32'h1);
            check("rst_is_equal", {31'h0, is_equal}, 32'h0);
            check("rst_alu_cin", {31'h0, alu_cin}, 32'h1);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         check("busy", {31'h0, busy}, (k <= 5) ? 32'h1 : 32'h0);
         check("done", {31'h0, done}, (k == 5) ? 32'h1 : 32'h0);
      end
      check("result_held", {16'h0, result}, {16'h0, e.r});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      op_a = '0; op_b = '0; op_sel = '0; op_mode = 1'b0; op_cin = 1'b1;
      #17;
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_result", {16'h0, result}, 32'h0);
      check("reset_cout", {31'h0, cout}, 32'h1);
      check("reset_is_equal", {31'h0, is_equal}, 32'h0);
      check("reset_alu_a", {28'h0, alu_a}, 32'h0);
      check("reset_alu_cin", {31'h0, alu_cin}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      run_op(16'h00FF, 16'h0001, 4'd9, 1'b0, 1'b1, 0, 0);
      run_op(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b1, 0, 0);
      run_op(16'h1234, 16'h0034, 4'd6, 1'b0, 1'b0, 0, 0);
      run_op(16'h0001, 16'h0002, 4'd6, 1'b0, 1'b0, 0, 0);
      run_op(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0, 0, 0);
      run_op(16'hABCD, 16'hABCD, 4'd6, 1'b1, 1'b0, 0, 0);
      run_op(16'h1111, 16'h2222, 4'd9, 1'b0, 1'b1, 2, 0);
      run_op(16'h8001, 16'h7FFF, 4'd9, 1'b0, 1'b1, 5, 0);
      run_op(16'h4321, 16'h1234, 4'd9, 1'b0, 1'b1, 0, 3);
      run_op(16'h4321, 16'h1234, 4'd9, 1'b0, 1'b1, 0, 0);

      for (int i = 0; i < 60; i++) begin
         logic [15:0] a, b;
         logic [3:0]  s;
         logic        m;
         logic [1:0]  pick;
         a = 16'($urandom);
         b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
         m = 1'($urandom);
         pick = 2'($urandom);
         if (m) s = 4'($urandom);
         else   s = (pick == 0) ? 4'd9 : (pick == 1) ? 4'd6 : (pick == 2) ? 4'd12 : 4'd15;
         run_op(a, b, s, m, 1'($urandom), 0, 0);
      end

      repeat (3) @(negedge clk);
      check("done_count", dones, issued);
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
